// File: rtl/pa_ifu_ras_pkg.sv
// Shared types and default sizes for the IFU return address stack.
// Imported by the RAS pointer controller and its pointer/count sub-module.
package pa_ifu_ras_pkg;
  localparam int ENTRY_NUM_D = 4;
  localparam int PTR_W_D     = 2;
  localparam int PC_W_D      = 24;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } ras_st_e;
endpackage

// File: rtl/pa_ifu_ras_ptr.sv
// Wrapping top-of-stack pointer with saturating occupancy count.
// o_*_nxt expose the push/pop result before any load is applied.
module pa_ifu_ras_ptr
  import pa_ifu_ras_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_D,
  parameter int PTR_W     = PTR_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_load,
  input  logic [PTR_W-1:0] i_load_ptr,
  input  logic [PTR_W:0]   i_load_cnt,
  output logic [PTR_W-1:0] o_ptr,
  output logic [PTR_W:0]   o_cnt,
  output logic [PTR_W-1:0] o_ptr_nxt,
  output logic [PTR_W:0]   o_cnt_nxt
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(ENTRY_NUM);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_cnt;
  logic             w_do_pop;

  assign w_do_pop = i_pop & ~i_push & (r_cnt != '0);

  always_comb begin
    o_ptr_nxt = r_ptr;
    o_cnt_nxt = r_cnt;
    unique case (1'b1)
      i_push: begin
        o_ptr_nxt = r_ptr + PTR_W'(1);
        o_cnt_nxt = (r_cnt == FULL) ? r_cnt
                  : r_cnt + (PTR_W+1)'(1);
      end
      w_do_pop: begin
        o_ptr_nxt = r_ptr - PTR_W'(1);
        o_cnt_nxt = r_cnt - (PTR_W+1)'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_ptr;
      r_cnt <= i_load_cnt;
    end else begin
      r_ptr <= o_ptr_nxt;
      r_cnt <= o_cnt_nxt;
    end
  end

  assign o_ptr = r_ptr;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pa_ifu_ras.sv
// RAS pointer and recovery controller top.
// Speculative/committed pointer tracking with one-cycle recovery.
module pa_ifu_ras_ctrl
  import pa_ifu_ras_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_D,
  parameter int PTR_W     = PTR_W_D,
  parameter int PC_W      = PC_W_D
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 id_pred_ras_link_vld,
  input  logic                 id_pred_ras_ret_vld,
  input  logic [PC_W-1:0]      id_pred_ras_link_pc,
  input  logic                 iu_ifu_link_vld,
  input  logic                 iu_ifu_ret_vld,
  input  logic                 iu_ifu_bht_mispred,
  input  logic                 iu_ifu_pc_mispred,
  input  logic                 iu_yy_xx_cancel,
  input  logic                 rtu_ifu_flush_fe,
  output logic [ENTRY_NUM-1:0] ras_entry_upd,
  output logic [PC_W-1:0]      ras_upd_pc,
  output logic [ENTRY_NUM-1:0] ras_rd_sel,
  output logic                 ras_pred_vld,
  output logic                 ras_recover
);
  ras_st_e          r_state;
  logic             w_idle;
  logic             w_rec_req;
  logic             w_spec_push;
  logic             w_spec_pop;
  logic             w_cmt_push;
  logic             w_cmt_pop;
  logic [PTR_W-1:0] w_spec_ptr;
  logic [PTR_W-1:0] w_spec_ptr_nxt;
  logic [PTR_W:0]   w_spec_cnt;
  logic [PTR_W:0]   w_spec_cnt_nxt;
  logic [PTR_W-1:0] w_cmt_ptr;
  logic [PTR_W-1:0] w_cmt_ptr_nxt;
  logic [PTR_W:0]   w_cmt_cnt;
  logic [PTR_W:0]   w_cmt_cnt_nxt;
  logic             w_unused;

  assign w_rec_req = rtu_ifu_flush_fe
                   | iu_ifu_bht_mispred
                   | (iu_ifu_pc_mispred & ~iu_ifu_link_vld)
                   | (iu_yy_xx_cancel & iu_ifu_ret_vld);

  assign w_idle      = (r_state == IDLE);
  assign w_spec_push = w_idle & id_pred_ras_link_vld & ~w_rec_req;
  assign w_spec_pop  = w_idle & id_pred_ras_ret_vld
                     & ~id_pred_ras_link_vld & ~w_rec_req;
  assign w_cmt_push  = ~rtu_ifu_flush_fe & iu_ifu_link_vld;
  assign w_cmt_pop   = ~rtu_ifu_flush_fe & ~iu_ifu_link_vld
                     & iu_ifu_ret_vld;

  // Restore takes the committed value after this cycle's IU update.
  pa_ifu_ras_ptr #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W)) u_spec (
    .clk        (forever_cpuclk),
    .rst        (cpurst),
    .i_push     (w_spec_push),
    .i_pop      (w_spec_pop),
    .i_load     (w_rec_req),
    .i_load_ptr (w_cmt_ptr_nxt),
    .i_load_cnt (w_cmt_cnt_nxt),
    .o_ptr      (w_spec_ptr),
    .o_cnt      (w_spec_cnt),
    .o_ptr_nxt  (w_spec_ptr_nxt),
    .o_cnt_nxt  (w_spec_cnt_nxt)
  );

  pa_ifu_ras_ptr #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W)) u_cmt (
    .clk        (forever_cpuclk),
    .rst        (cpurst),
    .i_push     (w_cmt_push),
    .i_pop      (w_cmt_pop),
    .i_load     (1'b0),
    .i_load_ptr ('0),
    .i_load_cnt ('0),
    .o_ptr      (w_cmt_ptr),
    .o_cnt      (w_cmt_cnt),
    .o_ptr_nxt  (w_cmt_ptr_nxt),
    .o_cnt_nxt  (w_cmt_cnt_nxt)
  );

  assign w_unused = ^{w_spec_cnt_nxt, w_cmt_ptr, w_cmt_cnt};

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) r_state <= IDLE;
    else        r_state <= w_rec_req ? RECOVER : IDLE;
  end

  assign ras_entry_upd = (w_spec_push & ~cpurst)
                       ? (ENTRY_NUM'(1) << w_spec_ptr_nxt)
                       : '0;
  assign ras_upd_pc    = id_pred_ras_link_pc;
  assign ras_rd_sel    = ENTRY_NUM'(1) << w_spec_ptr;
  assign ras_pred_vld  = w_idle & (w_spec_cnt != '0);
  assign ras_recover   = ~w_idle;
endmodule

// File: doc/pa_ifu_ras_ctrl.md
# pa_ifu_ras_ctrl

Pointer and recovery controller for the IFU return address stack (RAS). It keeps a speculative top-of-stack pointer and occupancy count, driven by ID-stage link (call) and return predictions. It also keeps a committed pointer and count, driven by IU-resolved link and return instructions. On flush or mispredict it restores the speculative state from the committed state through a one-cycle recovery state. It sits between ID prediction, the IU, and the RAS entry array, and drives the array's write enables and read select.

## Interface
- ENTRY_NUM, 4, number of RAS entries (power of 2, ≥2)
- PTR_W, 2, log2(ENTRY_NUM)
- PC_W, 24, stored return-PC width
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset, synchronous, active-high
- id_pred_ras_link_vld  in  1  ID predicts a call: push
- id_pred_ras_ret_vld  in  1  ID predicts a return: pop
- id_pred_ras_link_pc  in  PC_W  return address to push
- iu_ifu_link_vld  in  1  IU resolved a call
- iu_ifu_ret_vld  in  1  IU resolved a return
- iu_ifu_bht_mispred  in  1  branch direction mispredict
- iu_ifu_pc_mispred  in  1  target mispredict
- iu_yy_xx_cancel  in  1  IU cancel
- rtu_ifu_flush_fe  in  1  front-end flush
- ras_entry_upd  out  ENTRY_NUM  one-hot entry write enable
- ras_upd_pc  out  PC_W  write data for the entries
- ras_rd_sel  out  ENTRY_NUM  one-hot select of the top-of-stack entry
- ras_pred_vld  out  1  top-of-stack holds a valid prediction
- ras_recover  out  1  recovery cycle in progress

## Operation
**Speculative state**
- spec_ptr (PTR_W) indexes the most recently pushed entry.
- spec_cnt (0..ENTRY_NUM) holds the number of valid entries.

**Committed state**
- cmt_ptr and cmt_cnt follow the same rules as the speculative state, driven by IU events.

**Recovery trigger**
- rec_req = rtu_ifu_flush_fe | iu_ifu_bht_mispred | (iu_ifu_pc_mispred & ~iu_ifu_link_vld) | (iu_yy_xx_cancel & iu_ifu_ret_vld).

**Push (state IDLE, id_pred_ras_link_vld, ~rec_req)**
- Write the entry at spec_ptr+1 (mod ENTRY_NUM) with id_pred_ras_link_pc.
- spec_ptr += 1.
- spec_cnt = min(spec_cnt+1, ENTRY_NUM). When full, the oldest entry is overwritten.

**Pop (IDLE, id_pred_ras_ret_vld, ~link, ~rec_req)**
- If spec_cnt > 0: spec_ptr −= 1 and spec_cnt −= 1.
- If spec_cnt == 0: no change.

**Same-cycle ID events**
- Link and ret asserted together: link wins and ret is ignored.

**Commit update (every state, ~rtu_ifu_flush_fe)**
- iu_ifu_link_vld: push rule on cmt_ptr/cmt_cnt.
- Otherwise iu_ifu_ret_vld: pop rule.
- Link wins over ret.
- When rtu_ifu_flush_fe is asserted, no commit update happens.

**Recovery**
- rec_req in any state loads spec_ptr/spec_cnt with the cycle's next-committed values (cmt_*_nxt) and enters RECOVER.
- The ID push/pop in that cycle is dropped.

**FSM**
- IDLE → RECOVER on rec_req.
- RECOVER → IDLE after one cycle if ~rec_req.
- RECOVER → RECOVER if rec_req: re-restore, hold one more cycle.
- In RECOVER, ID events are dropped, ras_entry_upd = 0, and ras_pred_vld = 0.

**Outputs**
- ras_rd_sel = onehot(spec_ptr).
- ras_pred_vld = (state==IDLE) & (spec_cnt != 0).
- ras_recover = (state==RECOVER).
- ras_upd_pc = id_pred_ras_link_pc.

**Arithmetic**
- Pointer arithmetic wraps modulo ENTRY_NUM.
- Counts saturate at 0 and ENTRY_NUM and never wrap.

## Timing
**Reset (cpurst high at a clock edge)**
- spec_ptr = cmt_ptr = 0 and spec_cnt = cmt_cnt = 0; state IDLE.
- ras_rd_sel = 0…01, ras_pred_vld = 0, ras_recover = 0.
- ras_entry_upd = 0 while cpurst is high.
- Reset overrides every event in the same cycle, including a mid-recovery reset.

**Latency**
- ras_entry_upd and ras_upd_pc are combinational in the same cycle as id_pred_ras_link_vld; the entry captures at that edge.
- ras_rd_sel and ras_pred_vld come from registers and reflect a push or pop one cycle later. A push at cycle N gives rd_sel selecting the new entry at N+1.
- A recovery request at cycle N gives restored spec state and ras_recover=1 at N+1, and ras_pred_vld valid again at N+2.

**Simultaneous events**
- rec_req beats any ID event.
- The IU commit update and the recovery restore in the same cycle compose: the restore uses the post-commit value.

## Structure
- Shared package pa_ifu_ras_pkg holds:
  - the FSM state enum (IDLE, RECOVER);
  - the ENTRY_NUM/PTR_W/PC_W defaults.
- Natural sub-module: pa_ifu_ras_ptr, holding a pointer plus saturating count with push/pop/load ports.
  - Instantiated twice: speculative and committed.
- The entry array (pa_ifu_ras_entry instances) stays outside this block.

## Test plan
- Reset, then 3 pushes of PCs 0x100/0x200/0x300 → upd one-hot 0010, 0100, 1000; rd_sel = 1000; pred_vld = 1; spec_cnt = 3.
- 5 pushes on 4 entries → the fifth writes entry 1 (wrap); spec_cnt saturates at 4. Then 5 pops → pred_vld drops to 0 after the 4th pop and the ptr stops moving on the 5th.
- Link and ret asserted together → treated as a push only.
- 2 ID pushes and 1 IU link commit, then rtu_ifu_flush_fe → next cycle ras_recover = 1, spec_ptr = 1, spec_cnt = 1, pred_vld = 0. The cycle after: IDLE and pred_vld = 1.
- iu_ifu_pc_mispred with iu_ifu_link_vld=1 → no recovery; the commit push occurs. The same with link=0 → recovery.
- rec_req held for 2 cycles, plus cpurst asserted during RECOVER → back to reset values the next cycle and state IDLE.
